// File: rtl/rvv_backend_pkg.sv
// rvv_backend_pkg: shared uop payload type and ALU reservation-station depth
package rvv_backend_pkg;
  localparam int ALU_RS_DEPTH = 8;
  typedef struct packed {
    logic [7:0]  uop_id;
    logic [5:0]  funct6;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic        vm;
    logic [1:0]  vxrm;
    logic [31:0] rs1_data;
  } ALU_RS_t;
endpackage

// File: rtl/rvv_backend_alu_rs_if.sv
// rvv_backend_alu_rs_if: dispatch/issue handshake bundle of the ALU reservation station
interface rvv_backend_alu_rs_if;
  import rvv_backend_pkg::*;
  logic       push0_valid;
  ALU_RS_t    push0_uop;
  logic       push1_valid;
  ALU_RS_t    push1_uop;
  logic [1:0] push_ready;
  logic       flush;
  logic       alu_uop_valid;
  ALU_RS_t    alu_uop;
  logic       pop_rs;
  logic       rs_empty;
  logic       rs_full;
  modport master (
    output push0_valid, push0_uop, push1_valid, push1_uop, flush, pop_rs,
    input  push_ready, alu_uop_valid, alu_uop, rs_empty, rs_full
  );
  modport slave (
    input  push0_valid, push0_uop, push1_valid, push1_uop, flush, pop_rs,
    output push_ready, alu_uop_valid, alu_uop, rs_empty, rs_full
  );
endinterface

// File: rtl/rvv_backend_fifo_2w1r.sv
// rvv_backend_fifo_2w1r: generic in-order FIFO, two writes and one read per cycle, flushable
module rvv_backend_fifo_2w1r #(
  parameter type T = logic,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr0_en,
  input  T                       wr0_data,
  input  logic                   wr1_en,
  input  T                       wr1_data,
  input  logic                   rd_en,
  output T                       rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
  logic [CW-1:0] count_q, count_d;
  T mem_q [DEPTH];
  T mem_d [DEPTH];
  // wr1 lands right after wr0, or at wr_ptr itself when wr0 is suppressed
  always_comb begin
    wr1_ptr = wr_ptr_q + AW'(wr0_en);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_en);
    count_d = flush ? '0 : count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    mem_d = mem_q;
    if (!flush && wr0_en) mem_d[wr_ptr_q] = wr0_data;
    if (!flush && wr1_en) mem_d[wr1_ptr] = wr1_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/rvv_backend_alu_rs.sv
// rvv_backend_alu_rs: ALU reservation station, 2-wide dispatch, 1-wide issue; ALU_RS_BYPASS_EN adds empty-queue bypass
module rvv_backend_alu_rs
  import rvv_backend_pkg::*;
#(
  parameter int DEPTH = ALU_RS_DEPTH
) (
  input logic clk,
  input logic rst,
  rvv_backend_alu_rs_if.slave io
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] occ;
  logic acc0, acc1, pop, wr0, wr1, rd, byp;
  ALU_RS_t head;
  // credits come from registered occupancy only, so a same-cycle pop frees nothing
  always_comb begin
    io.push_ready = {occ <= CW'(DEPTH - 2), occ <= CW'(DEPTH - 1)};
    acc0 = io.push0_valid & io.push_ready[0];
    acc1 = io.push1_valid & acc0 & io.push_ready[1];
`ifdef ALU_RS_BYPASS_EN
    byp = io.rs_empty & !io.flush & io.push0_valid;
`else
    byp = 1'b0;
`endif
    io.alu_uop_valid = !io.rs_empty | byp;
    io.alu_uop = byp ? io.push0_uop : head;
    pop = io.pop_rs & io.alu_uop_valid;
    wr0 = acc0 & !(byp & pop);
    wr1 = acc1;
    rd = pop & !byp;
  end
  assign io.rs_empty = occ == '0;
  assign io.rs_full = occ == CW'(DEPTH);
  rvv_backend_fifo_2w1r #(.T(ALU_RS_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(io.flush),
    .wr0_en(wr0),
    .wr0_data(io.push0_uop),
    .wr1_en(wr1),
    .wr1_data(io.push1_uop),
    .rd_en(rd),
    .rd_data(head),
    .count(occ)
  );
  a_push1_needs_push0: assert property (@(posedge clk) disable iff (rst) !(io.push1_valid && !io.push0_valid));
endmodule

// File: tb/tb_rvv_backend_alu_rs.sv
// tb_rvv_backend_alu_rs: directed and randomized checks of the ALU reservation station against a queue model
module tb_rvv_backend_alu_rs;
  import rvv_backend_pkg::*;
  localparam int DEPTH = 8;
  logic clk, rst;
  int tests, fails;
  ALU_RS_t mq[$];
  rvv_backend_alu_rs_if io ();
  rvv_backend_alu_rs #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(io));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ALU_RS_t rnd();
    return ALU_RS_t'({$urandom(), $urandom()});
  endfunction

  task automatic drive(input logic p0v, input ALU_RS_t p0, input logic p1v, input ALU_RS_t p1, input logic fl, input logic pr);
    io.push0_valid = p0v;
    io.push0_uop = p0;
    io.push1_valid = p1v;
    io.push1_uop = p1;
    io.flush = fl;
    io.pop_rs = pr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic model_byp();
`ifdef ALU_RS_BYPASS_EN
    return mq.size() == 0 && !io.flush && io.push0_valid;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    int n;
    logic byp, a0, a1, pv;
    n = mq.size();
    byp = model_byp();
    a0 = io.push0_valid && n <= DEPTH - 1;
    a1 = io.push1_valid && a0 && n <= DEPTH - 2;
    pv = n > 0 || byp;
    @(posedge clk);
    if (io.flush) mq.delete();
    else begin
      if (io.pop_rs && pv) begin
        if (byp) a0 = 1'b0;
        else void'(mq.pop_front());
      end
      if (a0) mq.push_back(io.push0_uop);
      if (a1) mq.push_back(io.push1_uop);
    end
    #1;
  endtask

  task automatic drain(output ALU_RS_t got[$]);
    got.delete();
    for (int i = 0; i < 4 * DEPTH && io.alu_uop_valid; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      got.push_back(io.alu_uop);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    #1;
    tests++; if (io.alu_uop_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", io.alu_uop_valid); end
    tests++; if (io.rs_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", io.rs_empty); end
    tests++; if (io.rs_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", io.rs_full); end
    tests++; if (io.push_ready !== 2'b11) begin fails++; $display("FAIL reset_ready: got %b expected 11", io.push_ready); end
  endtask

  task automatic test_single_push();
    ALU_RS_t a;
    a = rnd();
    drive(1'b1, a, 1'b0, '0, 1'b0, 1'b0);
    tick();
    idle();
    tests++; if (io.alu_uop_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", io.alu_uop_valid); end
    tests++; if (io.alu_uop !== a) begin fails++; $display("FAIL single_uop: got %h expected %h", io.alu_uop, a); end
    tests++; if (io.push_ready !== 2'b11) begin fails++; $display("FAIL single_ready: got %b expected 11", io.push_ready); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    idle();
    tests++; if (io.rs_empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty: got %b expected 1", io.rs_empty); end
  endtask

  task automatic test_fill();
    ALU_RS_t exp[$], got[$], a, b;
    for (int i = 0; i < 4; i++) begin
      a = rnd(); b = rnd();
      exp.push_back(a); exp.push_back(b);
      drive(1'b1, a, 1'b1, b, 1'b0, 1'b0);
      tick();
    end
    idle();
    tests++; if (io.rs_full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", io.rs_full); end
    tests++; if (io.push_ready !== 2'b00) begin fails++; $display("FAIL fill_ready: got %b expected 00", io.push_ready); end
    drive(1'b1, rnd(), 1'b1, rnd(), 1'b0, 1'b0);
    tick();
    idle();
    drain(got);
    tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL fill_count: got %0d expected %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL fill_order[%0d]: got %h expected %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_occ7();
    ALU_RS_t exp[$], got[$], a, b;
    for (int i = 0; i < 7; i++) begin
      a = rnd();
      exp.push_back(a);
      drive(1'b1, a, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    a = rnd(); b = rnd();
    drive(1'b1, a, 1'b1, b, 1'b0, 1'b1);
    tests++; if (io.push_ready !== 2'b01) begin fails++; $display("FAIL occ7_ready_pre: got %b expected 01", io.push_ready); end
    tick();
    idle();
    void'(exp.pop_front());
    exp.push_back(a);
    tests++; if (io.push_ready !== 2'b01) begin fails++; $display("FAIL occ7_ready_post: got %b expected 01", io.push_ready); end
    tests++; if (io.rs_full !== 1'b0) begin fails++; $display("FAIL occ7_full: got %b expected 0", io.rs_full); end
    drain(got);
    tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL occ7_count: got %0d expected %0d", got.size(), exp.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL occ7_order[%0d]: got %h expected %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_flush();
    ALU_RS_t c;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, rnd(), 1'b0, '0, 1'b1, 1'b1);
    tick();
    idle();
    tests++; if (io.rs_empty !== 1'b1) begin fails++; $display("FAIL flush_empty: got %b expected 1", io.rs_empty); end
    tests++; if (io.alu_uop_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", io.alu_uop_valid); end
    tests++; if (io.push_ready !== 2'b11) begin fails++; $display("FAIL flush_ready: got %b expected 11", io.push_ready); end
    c = rnd();
    drive(1'b1, c, 1'b0, '0, 1'b0, 1'b0);
    tick();
    idle();
    tests++; if (io.alu_uop !== c) begin fails++; $display("FAIL flush_next_head: got %h expected %h", io.alu_uop, c); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    idle();
  endtask

  task automatic test_wrap();
    ALU_RS_t exp[$], got[$], a;
    for (int i = 0; i < 7; i++) begin
      a = rnd();
      exp.push_back(a);
      drive(1'b1, a, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      a = rnd();
      drive(1'b1, a, 1'b0, '0, 1'b0, 1'b1);
      tests++; if (io.alu_uop !== exp[0]) begin fails++; $display("FAIL wrap_head[%0d]: got %h expected %h", i, io.alu_uop, exp[0]); end
      tick();
      void'(exp.pop_front());
      exp.push_back(a);
      tests++; if (io.push_ready !== 2'b01) begin fails++; $display("FAIL wrap_occ[%0d]: got %b expected 01", i, io.push_ready); end
    end
    idle();
    drain(got);
    tests++; if (got.size() != 7) begin fails++; $display("FAIL wrap_count: got %0d expected 7", got.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    logic p0v, p1v, fl, pr, byp;
    logic [1:0] er;
    int n;
    for (int i = 0; i < 400; i++) begin
      p0v = $urandom_range(0, 2) != 0;
      p1v = p0v && $urandom_range(0, 1) == 1;
      fl = $urandom_range(0, 40) == 0;
      pr = $urandom_range(0, 2) == 0;
      drive(p0v, rnd(), p1v, rnd(), fl, pr);
      n = mq.size();
      byp = model_byp();
      er = {n <= DEPTH - 2, n <= DEPTH - 1};
      tests++; if (io.push_ready !== er) begin fails++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, io.push_ready, er); end
      tests++; if (io.alu_uop_valid !== (n > 0 || byp)) begin fails++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, io.alu_uop_valid, n > 0 || byp); end
      if (byp) begin
        tests++; if (io.alu_uop !== io.push0_uop) begin fails++; $display("FAIL rand_bypass[%0d]: got %h expected %h", i, io.alu_uop, io.push0_uop); end
      end else if (n > 0) begin
        tests++; if (io.alu_uop !== mq[0]) begin fails++; $display("FAIL rand_head[%0d]: got %h expected %h", i, io.alu_uop, mq[0]); end
      end
      tests++; if (io.rs_full !== (n == DEPTH)) begin fails++; $display("FAIL rand_full[%0d]: got %b expected %b", i, io.rs_full, n == DEPTH); end
      tick();
    end
    idle();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    idle();
  endtask

`ifdef ALU_RS_BYPASS_EN
  task automatic test_bypass();
    ALU_RS_t a, b;
    a = rnd(); b = rnd();
    drive(1'b1, a, 1'b1, b, 1'b0, 1'b1);
    tests++; if (io.alu_uop_valid !== 1'b1) begin fails++; $display("FAIL bypass_valid: got %b expected 1", io.alu_uop_valid); end
    tests++; if (io.alu_uop !== a) begin fails++; $display("FAIL bypass_uop: got %h expected %h", io.alu_uop, a); end
    tick();
    idle();
    tests++; if (io.alu_uop !== b) begin fails++; $display("FAIL bypass_next: got %h expected %h", io.alu_uop, b); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    idle();
    tests++; if (io.rs_empty !== 1'b1) begin fails++; $display("FAIL bypass_occ1: got %b expected 1", io.rs_empty); end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_push();
    test_fill();
    test_occ7();
    test_flush();
    test_wrap();
`ifdef ALU_RS_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rvv_backend_alu_rs.md
RVV_BACKEND_ALU_RS -- requirements
Module: rvv_backend_alu_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of uop entries (power of two, >=4).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port push0_valid  input  1  dispatch uop 0 valid (older).
REQ-005 SHALL have port push0_uop  input  ALU_RS_t  dispatch uop 0 payload.
REQ-006 SHALL have port push1_valid  input  1  dispatch uop 1 valid (younger).
REQ-007 SHALL have port push1_uop  input  ALU_RS_t  dispatch uop 1 payload.
REQ-008 SHALL have port push_ready  output  2  bit0: >=1 free entry; bit1: >=2 free entries.
REQ-009 SHALL have port flush  input  1  trap flush, discards all entries.
REQ-010 SHALL have port alu_uop_valid  output  1  head entry valid toward the ALU unit.
REQ-011 SHALL have port alu_uop  output  ALU_RS_t  head entry payload.
REQ-012 SHALL have port pop_rs  input  1  ALU unit consumes head entry.
REQ-013 SHALL have port rs_empty / rs_full  output  1 each  occupancy == 0 / == DEPTH.

Function
REQ-014 SHALL be in-order FIFO: 2 writes, 1 read per cycle; occupancy counter width $clog2(DEPTH)+1.
REQ-015 SHALL derive push_ready from registered occupancy only; a same-cycle pop grants no credit.
REQ-016 SHALL accept push0 iff push0_valid & push_ready[0]; push1 iff push1_valid & push0 accepted & push_ready[1].
REQ-017 SHALL write push0 at wr_ptr and push1 at wr_ptr+1 (mod DEPTH); wr_ptr advances by accepted count.
REQ-018 SHALL ignore push1_valid without push0_valid (not written; assertion fires).
REQ-019 SHALL pop iff pop_rs & alu_uop_valid; pop_rs while invalid is ignored.
REQ-020 SHALL drive alu_uop_valid = !rs_empty and alu_uop = entry[rd_ptr] (no bypass case).
REQ-021 SHALL make a pushed uop visible at head the cycle after its push (latency 1).
REQ-022 SHALL update occupancy = occ + pushes - pop in one cycle; pointers wrap modulo DEPTH.
REQ-023 SHALL, on flush, zero occupancy and both pointers next cycle; same-cycle pushes and pop are dropped.
REQ-024 SHALL give rst priority over flush; flush priority over push/pop.

Reset
REQ-025 SHALL, on rst, clear rd_ptr, wr_ptr, occupancy: alu_uop_valid=0, rs_empty=1, rs_full=0, push_ready=2'b11.
REQ-026 SHALL NOT reset payload storage; alu_uop value is don't-care while alu_uop_valid=0.

Configuration
REQ-027 SHALL support macro ALU_RS_BYPASS_EN.
REQ-028 With ALU_RS_BYPASS_EN: when rs_empty & !flush & push0_valid, alu_uop_valid=1 and alu_uop=push0_uop same cycle; if pop_rs then, push0 is not written and push1 (if accepted) is written at wr_ptr.
REQ-029 Without ALU_RS_BYPASS_EN: no combinational input-to-output path; REQ-020/021 apply always.

Structure
REQ-030 SHALL take ALU_RS_t and ALU_RS_DEPTH (default for DEPTH) from rvv_backend_pkg; no new typedefs local to the module.
REQ-031 SHALL place pointer/storage logic in one sub-module rvv_backend_fifo_2w1r (generic type T, DEPTH).

Verification
REQ-032 Reset then push0 A at cycle 0 -> cycle 1 alu_uop_valid=1, alu_uop=A, push_ready=2'b11.
REQ-033 Dual push A,B every cycle, pop_rs=0, DEPTH=8 -> after 4 cycles rs_full=1, push_ready=2'b00; pops return A,B in order.
REQ-034 Occupancy 7, push0+push1 valid, pop_rs=1 -> push_ready=2'b01, only push0 accepted, occupancy stays 7.
REQ-035 Occupancy 5, flush with push0 valid and pop_rs=1 -> next cycle rs_empty=1, alu_uop_valid=0, nothing written.
REQ-036 Pointer wrap: 20 single push/pop pairs, DEPTH=8 -> output order matches input order, occupancy constant.
REQ-037 ALU_RS_BYPASS_EN, empty, push0 A + push1 B + pop_rs -> same cycle alu_uop=A valid; next cycle alu_uop=B, occupancy 1.
